// File: rtl/hilo_div_seq_pkg.sv
// Purpose : shared types and constants for the HI/LO divide sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package hilo_div_seq_pkg;

  // Default operand width; the HI/LO result is twice this wide.
  localparam int unsigned DivWidth = 32;

  localparam logic [DivWidth-1:0] ZeroWord = '0;

  // Levels on start_i as driven by EX.
  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ZERO = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } div_state_e;

endpackage

// File: rtl/hilo_div_seq_div_step.sv
// Purpose : one radix-2 restoring divide iteration on the {rem,quo} pair.
// Latency : combinational.
// Backpressure: none.
// Ports   : pair = {rem,quo} in, divisor = unsigned divisor magnitude,
//           pair_next = {rem,quo} after one shift/trial-subtract step.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] pair,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] pair_next
);

  // After the left shift the upper WIDTH+1 bits are {rem, quo msb}.
  logic [WIDTH:0]   part;
  logic [WIDTH-1:0] quo_sh;
  // One extra bit so the borrow shows up as a sign bit.
  logic [WIDTH+1:0] trial;
  // rem < divisor holds on entry, so a committed difference fits in WIDTH
  // bits and its bit WIDTH is always zero.
  logic             unused_trial_msb;

  assign part             = pair[2*WIDTH-1:WIDTH-1];
  assign quo_sh           = {pair[WIDTH-2:0], 1'b0};
  assign trial            = {1'b0, part} - {2'b00, divisor};
  assign unused_trial_msb = trial[WIDTH];

  always_comb begin
    pair_next = {part[WIDTH-1:0], quo_sh};
    if (!trial[WIDTH+1]) begin
      pair_next = {trial[WIDTH-1:0], quo_sh[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/hilo_div_seq.sv
// Purpose : sequences DIV/DIVU into the HI/LO pair (remainder->HI, quotient->LO).
// Latency : WIDTH+1 cycles from the sampling edge to ready_o (2 for a zero divisor).
// Backpressure: stalls the pipeline while busy; holds DONE until EX drops start_i.
// Ports   : start_i/annul_i/signed_i/opdata1_i/opdata2_i from EX;
//           stallreq_o to the pipeline controller; ready_o, hi_o, lo_o,
//           hilo_we_o towards the MEM/WB HI/LO write port.
module hilo_div_seq
  import hilo_div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             annul_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  output logic             stallreq_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             hilo_we_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  div_state_e           state, state_d;
  logic [2*WIDTH-1:0]   pair;
  logic [2*WIDTH-1:0]   pair_next;
  logic [WIDTH-1:0]     divisor_q;
  logic [CntW-1:0]      cnt;
  logic                 neg_quo, neg_rem;
  logic                 first_done;

  logic                 go;
  logic                 div_zero;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign go       = (start_i == DivStart) && !annul_i;
  assign div_zero = (opdata2_i == '0);

  // The most negative value negates to itself, which read as unsigned is
  // exactly its magnitude, so no special case is needed.
  assign abs_a = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign abs_b = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  assign quo_fix = neg_quo ? -pair[WIDTH-1:0]       : pair[WIDTH-1:0];
  assign rem_fix = neg_rem ? -pair[2*WIDTH-1:WIDTH] : pair[2*WIDTH-1:WIDTH];

  div_step #(.WIDTH(WIDTH)) u_step (
    .pair      (pair),
    .divisor   (divisor_q),
    .pair_next (pair_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    stallreq_o = 1'b0;
    ready_o    = 1'b0;
    hilo_we_o  = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    case (state)
      ST_IDLE: begin
        stallreq_o = go;
        if (go) begin
          state_d = div_zero ? ST_ZERO : ST_RUN;
        end
      end
      ST_ZERO: begin
        stallreq_o = 1'b1;
        state_d    = annul_i ? ST_IDLE : ST_DONE;
      end
      ST_RUN: begin
        stallreq_o = 1'b1;
        if (annul_i) begin
          state_d = ST_IDLE;
        end else if (cnt == CntW'(WIDTH-1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ready_o   = 1'b1;
        hilo_we_o = first_done;
        hi_o      = rem_fix;
        lo_o      = quo_fix;
        if (annul_i || start_i == DivStop) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair       <= '0;
      divisor_q  <= '0;
      cnt        <= '0;
      neg_quo    <= 1'b0;
      neg_rem    <= 1'b0;
      first_done <= 1'b0;
    end else begin
      // Write strobe is armed only on the edge that enters DONE.
      first_done <= (state_d == ST_DONE) && (state != ST_DONE);
      case (state)
        ST_IDLE: begin
          if (go) begin
            cnt <= '0;
            if (div_zero) begin
              pair    <= '0;
              neg_quo <= 1'b0;
              neg_rem <= 1'b0;
            end else begin
              pair      <= {{WIDTH{1'b0}}, abs_a};
              divisor_q <= abs_b;
              neg_quo   <= signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              neg_rem   <= signed_i && opdata1_i[WIDTH-1];
            end
          end
        end
        ST_RUN: begin
          pair <= pair_next;
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_seq.sv
// Purpose : self-checking bench for hilo_div_seq with a result scoreboard.
// Latency : checks 33-cycle divide and 2-cycle zero-divisor timing.
// Backpressure: exercises start held in DONE, annul and async reset mid-run.
module tb_hilo_div_seq;
  import hilo_div_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, annul_i, signed_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        stallreq_o, ready_o, hilo_we_o;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int bad   = 0;
  int we_pulses = 0;
  logic [63:0] exp_q[$];

  hilo_div_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .stallreq_o (stallreq_o),
    .ready_o    (ready_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .hilo_we_o  (hilo_we_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (hilo_we_o === 1'b1) we_pulses++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {hi=remainder, lo=quotient}, truncating division via 64-bit math.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag);
    int   cyc;
    int   we0;
    bit   stall_ok;
    logic [63:0] exp;
    exp_q.push_back(model(sgn, a, b));
    @(negedge clk);
    signed_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    we0 = we_pulses;
    #1;
    stall_ok = (stallreq_o === 1'b1);
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (ready_o === 1'b1) break;
      if (stallreq_o !== 1'b1) stall_ok = 1'b0;
    end
    chk({tag, "_lat"}, 64'(cyc), (b == 32'd0) ? 64'd2 : 64'd33);
    chk({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
    chk({tag, "_stall_done"}, 64'(stallreq_o), 64'd0);
    chk({tag, "_we_first"}, 64'(hilo_we_o), 64'd1);
    exp = exp_q.pop_front();
    chk({tag, "_hilo"}, {hi_o, lo_o}, exp);
    if (hold > 1) begin
      repeat (hold - 1) @(posedge clk);
      #1;
      chk({tag, "_held"}, {63'd0, ready_o}, 64'd1);
      chk({tag, "_held_we"}, {63'd0, hilo_we_o}, 64'd0);
      chk({tag, "_held_hilo"}, {hi_o, lo_o}, exp);
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_idle"}, {62'd0, ready_o, stallreq_o}, 64'd0);
    chk({tag, "_we_cnt"}, 64'(we_pulses - we0), 64'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog run did not finish");
    $fatal(1);
  end

  initial begin
    int we0;
    rst_n = 1'b0; start_i = DivStop; annul_i = 1'b0; signed_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {61'd0, stallreq_o, ready_o, hilo_we_o}, 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, {ZeroWord, ZeroWord});
    @(negedge clk); rst_n = 1'b1;

    run_op(1'b0, 32'd100, 32'd7, 1, "divu_100_7");
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1, "div_m7_2");
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1, "div_7_m2");
    run_op(1'b0, 32'd5, 32'd0, 1, "divu_zero");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, "div_ovf");
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1, "divu_max_1");
    run_op(1'b1, 32'hFFFF_FFF0, 32'd0, 1, "div_zero_neg");
    run_op(1'b0, 32'd12345, 32'd99, 3, "hold3");

    // annul mid-RUN: no write, back to IDLE, then a normal divide.
    @(negedge clk);
    signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    we0 = we_pulses;
    repeat (10) @(posedge clk);
    @(negedge clk); annul_i = 1'b1;
    @(posedge clk); #1;
    chk("annul_idle", {62'd0, ready_o, stallreq_o}, 64'd0);
    @(negedge clk); annul_i = 1'b0; start_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("annul_no_we", 64'(we_pulses - we0), 64'd0);
    run_op(1'b1, 32'hFFFF_FC18, 32'd7, 1, "after_annul");

    // async reset mid-RUN: outputs drop at once, no write.
    @(negedge clk);
    signed_i = 1'b0; opdata1_i = 32'd777; opdata2_i = 32'd5; start_i = 1'b1;
    we0 = we_pulses;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0; start_i = 1'b0;
    #1;
    chk("rst_mid_ctl", {61'd0, stallreq_o, ready_o, hilo_we_o}, 64'd0);
    chk("rst_mid_hilo", {hi_o, lo_o}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("rst_no_we", 64'(we_pulses - we0), 64'd0);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        default: b = $urandom;
      endcase
      run_op(1'($urandom_range(0, 1)), a, b, 1 + $urandom_range(0, 2), "rand");
    end

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_div_seq.md
# hilo_div_seq

Sequencer for the HI/LO register pair. It runs a multi-cycle radix-2 restoring divide for DIV/DIVU and holds the pipeline stalled while it runs. When the divide completes, it issues a single-cycle write of remainder to HI and quotient to LO. It sits beside the EX stage, taking operands from EX, and drives the HI/LO write port through the MEM/WB path.

## Interface
- WIDTH, 32, operand width; the result is 2*WIDTH bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  divide request, held high by EX until ready_o is seen.
- annul_i  in  1  cancel the operation in flight (branch flush or exception).
- signed_i  in  1  1 = DIV (signed), 0 = DIVU; sampled with start_i.
- opdata1_i  in  WIDTH  dividend; sampled with start_i.
- opdata2_i  in  WIDTH  divisor; sampled with start_i.
- stallreq_o  out  1  stall request to the pipeline controller.
- ready_o  out  1  result valid.
- hi_o  out  WIDTH  remainder.
- lo_o  out  WIDTH  quotient.
- hilo_we_o  out  1  HI/LO write strobe, one cycle per completed divide.

## Operation
- States: IDLE, ZERO, RUN, DONE.
- IDLE
  - start_i=1 and annul_i=0 and divisor≠0: latch |dividend| and |divisor|, record sign flags, counter←0, go to RUN.
  - start_i=1 and annul_i=0 and divisor=0: go to ZERO.
  - Otherwise stay in IDLE.
- Absolute values and sign flags:
  - Computed only when signed_i=1.
  - The absolute value of the most negative number is itself; treat it as the unsigned magnitude 2^(WIDTH-1).
- ZERO
  - Result quotient=0, remainder=0.
  - Go to DONE next cycle.
- RUN
  - Per cycle: shift {rem,quo} left by one.
  - Trial subtract divisor from the upper (WIDTH+1)-bit partial remainder.
  - If the result is non-negative, commit it and set the quotient LSB to 1; otherwise keep the partial remainder and set the LSB to 0.
  - counter++; after WIDTH iterations go to DONE.
- DONE
  - Apply sign fixup: quotient negated if the dividend and divisor signs differ; remainder negated if the dividend was negative.
  - ready_o=1, and hi_o/lo_o are driven from the fixed-up result.
  - hilo_we_o=1 only in the first DONE cycle.
  - Stay in DONE while start_i=1; return to IDLE when start_i=0.
- annul_i=1 in ZERO, RUN or DONE: go to IDLE next edge. No further hilo_we_o is produced, and a pending result is discarded.
- stallreq_o = (state==ZERO) | (state==RUN) | (state==IDLE & start_i & ~annul_i). It is deasserted in DONE.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This is the natural modulo-2^WIDTH result; no trap.
- Reset:
  - Outputs: state=IDLE, all outputs 0, hi_o=lo_o=0.
  - Reset mid-RUN abandons the operation without a write.

## Timing
- start_i sampled at edge N (state IDLE).
- Nonzero divisor: RUN occupies cycles N+1..N+WIDTH; ready_o and hilo_we_o are high in cycle N+WIDTH+1 (N+33 for WIDTH=32).
- Zero divisor: ZERO in N+1; ready_o and hilo_we_o in N+2.
- hilo_we_o is a single-cycle pulse per operation even if start_i stays high for several DONE cycles.
- A new operation can start no earlier than one cycle after start_i is seen low in DONE (through IDLE).
- annul_i wins over start_i in the same cycle; annul_i in IDLE is a no-op.

## Structure
- Shared package holds:
  - State encoding (2 bits): IDLE=2'b00, ZERO=2'b01, RUN=2'b10, DONE=2'b11.
  - ZeroWord.
  - WIDTH default.
  - DivStart/DivStop constants for start_i.
- One natural sub-module: div_step. It is combinational: it takes the {rem,quo} pair and the divisor and returns the next pair. It keeps the iteration logic separate from the FSM and can be unit-tested on its own.
- The sign fixup and absolute-value logic stay inline in hilo_div_seq.

## Test plan
- DIVU 100/7, start held: ready_o at N+33, hilo_we_o for exactly one cycle; lo=14, hi=2; stallreq_o high N..N+32.
- DIV 0xFFFFFFF9 (-7) / 2: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 7/0xFFFFFFFE: lo=0xFFFFFFFD, hi=1.
- DIVU 5/0: ZERO path, ready_o at N+2, lo=hi=0, one write pulse.
- DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0, no error. DIVU 0xFFFFFFFF/1: lo=0xFFFFFFFF, hi=0.
- annul_i pulsed at RUN iteration 10: IDLE next edge, stallreq_o low, hilo_we_o never asserted. A new start then completes normally in 33 cycles.
- rst_n low asynchronously mid-RUN: all outputs 0 immediately, no write. start_i held through 3 DONE cycles: a single hilo_we_o pulse, then IDLE after start_i falls.
